// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI4-Stream arbiter: packet-locked grant, one-cycle arbitration
// bubble, completed-packet counter on the master port.
module axis_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  localparam int GW     = $clog2(NUM_SRC)
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_areset,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [GW-1:0]             grant,
  output logic                      busy,
  output logic [15:0]               pkt_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic [GW-1:0]     rr_idx;
  logic [GW-1:0]     rr_pick;
  logic              rr_found;
  logic              end_of_pkt;
  logic [DATA_W-1:0] src_data [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = s_axis_tdata[g*DATA_W +: DATA_W];
  end

  // Search starts just past the last-served source so it gets lowest priority.
  always_comb begin
    rr_idx   = '0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      rr_idx = GW'((int'(last_q) + i) % NUM_SRC);
      if (!rr_found && s_axis_tvalid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    pkt_count_d   = pkt_count_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    busy          = 1'b0;
    end_of_pkt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy                   = 1'b1;
        m_axis_tdata           = src_data[grant_q];
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tlast           = s_axis_tlast[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        end_of_pkt = s_axis_tvalid[grant_q] & s_axis_tlast[grant_q] & m_axis_tready;
        if (end_of_pkt) begin
          last_d      = grant_q;
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves the pointer on the top source so source 0 wins first.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_SRC - 1);
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign grant     = grant_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 sources, 8-bit data).
module tb_axis_rr_arbiter;

  logic        m_axis_aclk;
  logic        m_axis_areset;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tlast;
  logic [3:0]  s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] pkt_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] beat_log [$];

  axis_rr_arbiter #(.NUM_SRC(4), .DATA_W(8)) dut (
    .m_axis_aclk   (m_axis_aclk),
    .m_axis_areset (m_axis_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  initial m_axis_aclk = 1'b0;
  always #5 m_axis_aclk = ~m_axis_aclk;

  // Beats that will complete on the coming rising edge, sampled mid-cycle.
  always @(negedge m_axis_aclk) begin
    if (!m_axis_areset && m_axis_tvalid && m_axis_tready)
      beat_log.push_back(m_axis_tdata);
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic step();
    @(posedge m_axis_aclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] valid, input logic [3:0] last,
                                input logic [31:0] data, input logic ready);
    s_axis_tvalid = valid;
    s_axis_tlast  = last;
    s_axis_tdata  = data;
    m_axis_tready = ready;
    #1;
  endtask

  task automatic reset_dut();
    m_axis_areset = 1'b1;
    apply_stimulus(4'b0000, 4'b0000, 32'h0, 1'b1);
    repeat (2) step();
    m_axis_areset = 1'b0;
  endtask

  logic        t4_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0]  t4_dat [6] = '{8'hC1, 8'hC2, 8'hC2, 8'hC2, 8'hC3, 8'hC4};
  logic        t4_lst [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0]  t4_exp [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};

  initial begin
    m_axis_areset = 1'b0;
    apply_stimulus(4'b0000, 4'b0000, 32'h0, 1'b1);
    #2 m_axis_areset = 1'b1;
    #1;
    check_output("rst tvalid", 32'(m_axis_tvalid), 32'h0);
    check_output("rst busy", 32'(busy), 32'h0);
    check_output("rst pkt_count", 32'(pkt_count), 32'h0);
    check_output("rst grant", 32'(grant), 32'h0);
    check_output("rst s_tready", 32'(s_axis_tready), 32'h0);
    repeat (2) step();
    m_axis_areset = 1'b0;

    // Source 1 sends a three-beat packet after one bubble cycle
    apply_stimulus(4'b0010, 4'b0000, 32'h0000_1100, 1'b1);
    check_output("t1 bubble tvalid", 32'(m_axis_tvalid), 32'h0);
    step();
    check_output("t1 grant", 32'(grant), 32'h1);
    check_output("t1 busy", 32'(busy), 32'h1);
    check_output("t1 beat0", 32'(m_axis_tdata), 32'h11);
    check_output("t1 s_tready", 32'(s_axis_tready), 32'h2);
    step();
    apply_stimulus(4'b0010, 4'b0000, 32'h0000_2200, 1'b1);
    check_output("t1 beat1", 32'(m_axis_tdata), 32'h22);
    step();
    apply_stimulus(4'b0010, 4'b0010, 32'h0000_3300, 1'b1);
    check_output("t1 beat2", 32'(m_axis_tdata), 32'h33);
    check_output("t1 tlast", 32'(m_axis_tlast), 32'h1);
    step();
    apply_stimulus(4'b0000, 4'b0000, 32'h0, 1'b1);
    check_output("t1 pkt_count", 32'(pkt_count), 32'h1);
    check_output("t1 idle busy", 32'(busy), 32'h0);
    check_output("t1 idle tvalid", 32'(m_axis_tvalid), 32'h0);
    check_output("t1 grant held", 32'(grant), 32'h1);

    // All four sources request continuously with two-beat packets
    reset_dut();
    for (int p = 0; p < 5; p++) begin
      apply_stimulus(4'b1111, 4'b0000, 32'h4030_2010, 1'b1);
      check_output("t2 bubble busy", 32'(busy), 32'h0);
      step();
      check_output("t2 grant", 32'(grant), 32'(p % 4));
      check_output("t2 beat0", 32'(m_axis_tdata), 32'(((p % 4) + 1) * 16));
      step();
      apply_stimulus(4'b1111, 4'b1111, 32'h4131_2111, 1'b1);
      check_output("t2 beat1", 32'(m_axis_tdata), 32'(((p % 4) + 1) * 16 + 1));
      check_output("t2 tlast", 32'(m_axis_tlast), 32'h1);
      step();
    end
    check_output("t2 pkt_count", 32'(pkt_count), 32'h5);

    // Source 2 requests mid-packet and must wait for source 0's tlast
    reset_dut();
    apply_stimulus(4'b0001, 4'b0000, 32'h0000_00A1, 1'b1);
    step();
    check_output("t3 grant0", 32'(grant), 32'h0);
    apply_stimulus(4'b0101, 4'b0000, 32'h00B1_00A1, 1'b1);
    check_output("t3 s_tready a", 32'(s_axis_tready), 32'h1);
    check_output("t3 beat0", 32'(m_axis_tdata), 32'hA1);
    step();
    apply_stimulus(4'b0100, 4'b0000, 32'h00B2_0000, 1'b1);
    check_output("t3 gap tvalid", 32'(m_axis_tvalid), 32'h0);
    check_output("t3 gap busy", 32'(busy), 32'h1);
    check_output("t3 s_tready b", 32'(s_axis_tready), 32'h1);
    step();
    apply_stimulus(4'b0101, 4'b0001, 32'h00B3_00A2, 1'b1);
    check_output("t3 beat1", 32'(m_axis_tdata), 32'hA2);
    check_output("t3 tlast", 32'(m_axis_tlast), 32'h1);
    step();
    apply_stimulus(4'b0101, 4'b0000, 32'h00B4_00A3, 1'b1);
    check_output("t3 idle busy", 32'(busy), 32'h0);
    check_output("t3 idle s_tready", 32'(s_axis_tready), 32'h0);
    step();
    check_output("t3 grant2", 32'(grant), 32'h2);
    apply_stimulus(4'b0101, 4'b0100, 32'h00B4_00A3, 1'b1);
    check_output("t3 src2 data", 32'(m_axis_tdata), 32'hB4);
    check_output("t3 src2 s_tready", 32'(s_axis_tready), 32'h4);
    check_output("t3 single tlast", 32'(m_axis_tlast), 32'h1);
    step();
    check_output("t3 pkt_count", 32'(pkt_count), 32'h2);
    step();
    check_output("t3 grant back0", 32'(grant), 32'h0);

    // Downstream stalls during a four-beat packet
    reset_dut();
    apply_stimulus(4'b0001, 4'b0000, 32'h0000_00C1, 1'b0);
    step();
    beat_log.delete();
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(4'b0001, {3'b000, t4_lst[k]}, {24'h0, t4_dat[k]}, t4_rdy[k]);
      check_output("t4 stall data", 32'(m_axis_tdata), 32'(t4_dat[k]));
      step();
    end
    apply_stimulus(4'b0000, 4'b0000, 32'h0, 1'b1);
    check_output("t4 beat count", 32'(beat_log.size()), 32'h4);
    for (int k = 0; k < 4; k++)
      if (k < beat_log.size()) check_output("t4 beat order", 32'(beat_log[k]), 32'(t4_exp[k]));
    check_output("t4 pkt_count", 32'(pkt_count), 32'h1);

    // Reset lands in the middle of a four-beat packet
    apply_stimulus(4'b0001, 4'b0000, 32'h0000_00D1, 1'b1);
    step();
    check_output("t5 grant0", 32'(grant), 32'h0);
    step();
    apply_stimulus(4'b0001, 4'b0000, 32'h0000_00D2, 1'b1);
    check_output("t5 beat2 tvalid", 32'(m_axis_tvalid), 32'h1);
    m_axis_areset = 1'b1;
    #1;
    check_output("t5 rst tvalid", 32'(m_axis_tvalid), 32'h0);
    check_output("t5 rst busy", 32'(busy), 32'h0);
    check_output("t5 rst pkt_count", 32'(pkt_count), 32'h0);
    check_output("t5 rst s_tready", 32'(s_axis_tready), 32'h0);
    step();
    apply_stimulus(4'b1000, 4'b1000, 32'hE300_0000, 1'b1);
    m_axis_areset = 1'b0;
    check_output("t5 post-rst busy", 32'(busy), 32'h0);
    step();
    check_output("t5 grant3", 32'(grant), 32'h3);
    check_output("t5 src3 data", 32'(m_axis_tdata), 32'hE3);
    step();
    apply_stimulus(4'b0000, 4'b0000, 32'h0, 1'b1);
    check_output("t5 pkt_count", 32'(pkt_count), 32'h1);

    // Packet counter wraps from 0xFFFF to 0x0000
    reset_dut();
    apply_stimulus(4'b0001, 4'b0001, 32'h0000_005A, 1'b1);
    repeat (131070) step();
    check_output("t6 pkt_count max", 32'(pkt_count), 32'hFFFF);
    check_output("t6 busy", 32'(busy), 32'h0);
    repeat (2) step();
    check_output("t6 pkt_count wrap", 32'(pkt_count), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
